mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_lat_counter.sv | 45 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the main-memory arbiter and the cache controller.
//   arb_state_t      : arbiter FSM states (IDLE, BUSY, DONE)
//   arb_side_t       : identifies the instruction or data requester
//   MEM_LAT_DEFAULT  : default main-memory latency in cycles (legal 1..15)
//   LAT_CNT_W        : latency counter width, wide enough for the full range
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

    localparam int MEM_LAT_DEFAULT = 4;
    localparam int LAT_CNT_W       = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
// Counts the cycles of one main-memory access.
//   clk, rst_b : clock, asynchronous active-low reset
//   clr_i      : restart the count at 0 on the next edge (wins over en_i)
//   en_i       : advance the count by one per cycle
//   tc_o       : high while enabled and the count equals TERM
// -----------------------------------------------------------------------------
module mem_lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int W    = LAT_CNT_W,
    parameter int TERM = MEM_LAT_DEFAULT - 1
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == W'(TERM));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates instruction-refill and data miss-handling requests onto a single
// main-memory port. One transaction at a time: IDLE -> BUSY (MEM_LAT cycles)
// -> DONE (one-cycle done pulse to the granted side) -> IDLE.
//   i_req/i_addr/i_done           : instruction side (read only)
//   d_req/d_we/d_addr/d_wdata/d_done : data side (refill or write-back)
//   rdata                         : read data, valid with i_done/d_done
//   mem_addr/mem_we/mem_din/mem_dout : main-memory port
//   busy                          : high whenever the FSM is not IDLE
// Build option: MEM_ARB_RR_EN selects round-robin on simultaneous requests;
// when undefined the data side always wins a tie.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    arb_state_t    state_q;
    arb_side_t     side_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          mem_we_q;
    logic          i_done_q;
    logic          d_done_q;

    arb_side_t     grant_side_d;
    logic [AW-1:0] grant_addr_d;
    logic          grant_we_d;
    logic [DW-1:0] grant_wdata_d;

    logic          lat_clr;
    logic          lat_en;
    logic          lat_tc;

    // A grant happens on any edge where the FSM is idle and someone asks.
    assign lat_clr = (state_q == IDLE) && (i_req || d_req);
    assign lat_en  = (state_q == BUSY);

`ifdef MEM_ARB_RR_EN
    arb_side_t last_grant_q;

    // On a tie the side not served last wins; a lone requester always wins.
    always_comb begin
        if (i_req && d_req) begin
            grant_side_d = (last_grant_q == SIDE_D) ? SIDE_I : SIDE_D;
        end else begin
            grant_side_d = d_req ? SIDE_D : SIDE_I;
        end
    end

    // Starts at "instruction" so the data side wins the first tie.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_grant_q <= SIDE_I;
        end else if (lat_clr) begin
            last_grant_q <= grant_side_d;
        end
    end
`else
    assign grant_side_d = d_req ? SIDE_D : SIDE_I;
`endif

    // The instruction side never writes, so it latches a read with zero data.
    always_comb begin
        if (grant_side_d == SIDE_D) begin
            grant_addr_d  = d_addr;
            grant_we_d    = d_we;
            grant_wdata_d = d_wdata;
        end else begin
            grant_addr_d  = i_addr;
            grant_we_d    = 1'b0;
            grant_wdata_d = '0;
        end
    end

    mem_lat_counter #(
        .W    (LAT_CNT_W),
        .TERM (MEM_LAT - 1)
    ) u_lat_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr_i (lat_clr),
        .en_i  (lat_en),
        .tc_o  (lat_tc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            side_q   <= SIDE_I;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mem_we_q <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each edge so they last one cycle.
            mem_we_q <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (lat_clr) begin
                        side_q   <= grant_side_d;
                        addr_q   <= grant_addr_d;
                        wdata_q  <= grant_wdata_d;
                        mem_we_q <= grant_we_d;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (lat_tc) begin
                        rdata_q  <= mem_dout;
                        i_done_q <= (side_q == SIDE_I);
                        d_done_q <= (side_q == SIDE_D);
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign rdata    = rdata_q;
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign mem_we   = mem_we_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two requester drivers (instruction = side 0, data = side 1) replay queued
// transactions following the hold-until-done handshake. A transaction-level
// reference model decides grants from the request lines and the free time of
// the memory port, pushing the expected completion into a scoreboard queue;
// a monitor compares every cycle and pops on each done pulse.
// Compile with +define+MEM_ARB_RR_EN to check the round-robin build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = MEM_LAT_DEFAULT;

    logic          clk   = 1'b0;
    logic          rst_b = 1'b0;
    logic          i_req, d_req, d_we;
    logic          i_done, d_done, mem_we, busy;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, rdata, mem_din, mem_dout;

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            pre_gap;
        int            drop;
    } txn_t;

    typedef struct {
        int   side;
        int   done_edge;
        logic we;
    } exp_t;

    // Requester-side signals, index 0 = instruction, 1 = data.
    logic          drv_req   [2];
    logic          drv_we    [2];
    logic [AW-1:0] drv_addr  [2];
    logic [DW-1:0] drv_wdata [2];
    int            phase     [2];
    txn_t          stim_q    [2][$];

    assign i_req   = drv_req[0];
    assign i_addr  = drv_addr[0];
    assign d_req   = drv_req[1];
    assign d_we    = drv_we[1];
    assign d_addr  = drv_addr[1];
    assign d_wdata = drv_wdata[1];

    // Reference model state.
    exp_t          exp_q[$];
    int            edge_n    = 0;
    int            free_edge = 0;
    int            cur_g     = -1000;
    logic          cur_we    = 1'b0;
    logic [AW-1:0] cur_addr  = '0;
    logic [DW-1:0] cur_din   = '0;
    bit            last_d    = 1'b0;
    logic [DW-1:0] dout_at [256];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (L)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input int s, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int gap, input int drop);
        txn_t t;
        t.we      = (s == 1) ? we : 1'b0;
        t.addr    = addr;
        t.wdata   = wdata;
        t.pre_gap = gap;
        t.drop    = drop;
        stim_q[s].push_back(t);
    endtask

    // Requester: wait pre_gap cycles, raise req and hold until done (or drop
    // it early if asked), then release it while done is visible.
    task automatic run_driver(input int s);
        txn_t t;
        int   gap;
        int   drop_cnt;
        int   wait_cnt;
        gap = 0; drop_cnt = 0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                drv_req[s] = 1'b0;
                phase[s]   = 0;
            end else begin
                if (phase[s] == 0 && stim_q[s].size() != 0) begin
                    t        = stim_q[s].pop_front();
                    gap      = t.pre_gap;
                    phase[s] = 1;
                end
                if (phase[s] == 1) begin
                    if (gap == 0) begin
                        drv_req[s]   = 1'b1;
                        drv_we[s]    = t.we;
                        drv_addr[s]  = t.addr;
                        drv_wdata[s] = t.wdata;
                        drop_cnt     = t.drop;
                        wait_cnt     = 0;
                        phase[s]     = 2;
                    end else begin
                        gap--;
                    end
                end else if (phase[s] == 2) begin
                    wait_cnt++;
                    if ((s == 1) ? d_done : i_done) begin
                        drv_req[s] = 1'b0;
                        phase[s]   = 0;
                    end else if (drop_cnt > 0) begin
                        drop_cnt--;
                        if (drop_cnt == 0) drv_req[s] = 1'b0;
                    end else if (!drv_req[s] && wait_cnt > 4 * L + 8) begin
                        phase[s] = 0;
                    end
                end
            end
        end
    endtask

    // Memory returns a fresh random word every cycle, stable across the cycle.
    initial begin : mem_model
        mem_dout = $urandom;
        forever begin
            @(posedge clk);
            #1 mem_dout = $urandom;
        end
    end

    // Transaction-level reference: the port is free L+2 edges after a grant;
    // done is expected L edges after the grant edge, carrying the memory word
    // present during the cycle before that edge.
    initial begin : ref_model
        int win;
        forever begin
            @(posedge clk or negedge rst_b);
            if (!rst_b) begin
                exp_q.delete();
                free_edge = 0;
                cur_g     = -1000;
                cur_we    = 1'b0;
                cur_addr  = '0;
                cur_din   = '0;
                last_d    = 1'b0;
            end else begin
                edge_n++;
                dout_at[edge_n % 256] = mem_dout;
                if (edge_n >= free_edge && (drv_req[0] || drv_req[1])) begin
`ifdef MEM_ARB_RR_EN
                    if (drv_req[0] && drv_req[1]) win = last_d ? 0 : 1;
                    else                          win = drv_req[1] ? 1 : 0;
`else
                    win = drv_req[1] ? 1 : 0;
`endif
                    last_d    = (win == 1);
                    cur_g     = edge_n;
                    cur_we    = (win == 1) && drv_we[1];
                    cur_addr  = drv_addr[win];
                    cur_din   = drv_wdata[1];
                    free_edge = edge_n + L + 2;
                    exp_q.push_back('{side: win, done_edge: edge_n + L, we: cur_we});
                end
            end
        end
    end

    initial begin : monitor
        bit   in_busy;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                check("rst_busy",   busy,     1'b0);
                check("rst_done",   {i_done, d_done}, 2'b00);
                check("rst_mem_we", mem_we,   1'b0);
                check("rst_rdata",  rdata,    '0);
                check("rst_addr",   mem_addr, '0);
                check("rst_din",    mem_din,  '0);
            end else begin
                in_busy = (edge_n >= cur_g) && (edge_n <= cur_g + L);
                check("busy",     busy,     in_busy);
                check("mem_we",   mem_we,   (edge_n == cur_g) && cur_we);
                check("mem_addr", mem_addr, cur_addr);
                if (edge_n == cur_g && cur_we) check("mem_din", mem_din, cur_din);
                if (i_done || d_done) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_done", {i_done, d_done}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_pair", {i_done, d_done}, (e.side == 1) ? 2'b01 : 2'b10);
                        check("done_edge", edge_n, e.done_edge);
                        if (!e.we) check("rdata", rdata, dout_at[e.done_edge % 256]);
                    end
                end
                if (exp_q.size() != 0 && exp_q[0].done_edge < edge_n) begin
                    check("done_missing", edge_n, exp_q[0].done_edge);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drain();
        int cyc;
        cyc = 0;
        while (stim_q[0].size() != 0 || stim_q[1].size() != 0 || phase[0] != 0 ||
               phase[1] != 0 || exp_q.size() != 0 || edge_n < free_edge) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d requests still pending after %0d cycles",
                         exp_q.size(), cyc);
                exp_q.delete();
                return;
            end
        end
        @(negedge clk);
    endtask

    initial begin : main
        int start;
        int side;
        for (int s = 0; s < 2; s++) begin
            drv_req[s]   = 1'b0;
            drv_we[s]    = 1'b0;
            drv_addr[s]  = '0;
            drv_wdata[s] = '0;
            phase[s]     = 0;
        end
        fork
            run_driver(0);
            run_driver(1);
        join_none

        repeat (3) @(negedge clk);
        #2 rst_b = 1'b1;

        // Data refill read at 0x40.
        push(1, 1'b0, 32'h40, 32'h1234_5678, 0, 0);
        drain();
        // Data write-back of 0xDEADBEEF to 0x80.
        push(1, 1'b1, 32'h80, 32'hDEAD_BEEF, 0, 0);
        drain();
        // Both sides asking for two transactions each at the same time.
        push(1, 1'b0, 32'h100, 32'h0, 0, 0);
        push(1, 1'b0, 32'h104, 32'h0, 0, 0);
        push(0, 1'b0, 32'h200, 32'h0, 0, 0);
        push(0, 1'b0, 32'h204, 32'h0, 0, 0);
        drain();
        // Data drops req mid-BUSY while instruction arrives during BUSY.
        push(1, 1'b0, 32'h300, 32'h0, 0, 2);
        push(0, 1'b0, 32'h400, 32'h0, 2, 0);
        drain();

        // Reset in BUSY cycle 2 of an instruction refill, then re-request.
        start = edge_n;
        push(0, 1'b0, 32'h500, 32'h0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cur_g > start && edge_n == cur_g + 2) break;
        end
        #2 rst_b = 1'b0;
        #1;
        check("abort_busy",   busy,   1'b0);
        check("abort_i_done", i_done, 1'b0);
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_rdata",  rdata,  '0);
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b1;
        push(0, 1'b0, 32'h504, 32'h0, 0, 0);
        drain();

        // Randomized mix on both sides.
        for (int n = 0; n < 100; n++) begin
            side = $urandom_range(0, 1);
            push(side, 1'($urandom), $urandom, $urandom, $urandom_range(0, 4), 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
